// File: rtl/spi_resp_defs.sv
// Shared state encodings and framing constants for the SPI responder.
package spi_resp_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CMD     = 2'd1,
    ST_DATA_WR = 2'd2,
    ST_DATA_RD = 2'd3
  } state_t;

  // Write/read select bit inside the command byte.
  localparam int CMD_W_BIT = 7;
  // SPI bits per command or data byte.
  localparam int BYTE_BITS = 8;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchroniser for one SPI pin, with rise/fall pulses taken
// from the two oldest stages so edges line up with the synchronised level.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], i_pin};
  end

  assign o_level = r_sync[STAGES-1];
  assign o_rise  =  r_sync[STAGES-2] & ~r_sync[STAGES-1];
  assign o_fall  = ~r_sync[STAGES-2] &  r_sync[STAGES-1];

endmodule

// File: rtl/spi_responder.sv
// SPI peripheral endpoint: command byte then data bytes into/out of a
// small register file, with a local write strobe and async read port.
//
// state      | meaning
// ST_IDLE    | deselected, waiting for ss rise
// ST_CMD     | shifting in the command byte
// ST_DATA_WR | each full byte commits to regfile[ptr], ptr++
// ST_DATA_RD | shifting regfile[ptr] out on miso, ptr++ per byte
module spi_responder
  import spi_resp_defs::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              mosi,
  input  logic              ss,
  output logic              miso,
  output logic              miso_oe,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(BYTE_BITS);

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0]     r_bit_cnt;
  logic [BYTE_BITS-2:0] r_shift_in;
  logic [DATA_W-1:0]    r_shift_out;
  logic [ADDR_W-1:0]    r_ptr;
  logic                 r_miso_oe;
  logic                 r_wr_strobe;
  logic [ADDR_W-1:0]    r_wr_addr;
  logic [DATA_W-1:0]    r_wr_data;
  logic                 r_frame_err;
  logic [DATA_W-1:0]    r_regs [DEPTH];

  logic w_sck_rise, w_sck_fall, w_sck_level_unused;
  logic w_ss_level, w_ss_rise, w_ss_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .i_pin(sck),
    .o_level(w_sck_level_unused), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .rst_n(rst_n), .i_pin(ss),
    .o_level(w_ss_level), .o_rise(w_ss_rise), .o_fall(w_ss_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .i_pin(mosi),
    .o_level(w_mosi), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  // sck edges only count inside an active frame with no select change pending.
  logic                 w_sck_live, w_rise_ev, w_fall_ev, w_last_bit;
  logic [BYTE_BITS-1:0] w_byte;
  logic [ADDR_W-1:0]    w_cmd_addr, w_ptr_inc;

  assign w_sck_live = (r_state != ST_IDLE) && w_ss_level && !w_ss_rise && !w_ss_fall;
  assign w_rise_ev  = w_sck_live && w_sck_rise;
  assign w_fall_ev  = w_sck_live && w_sck_fall;
  assign w_last_bit = (r_bit_cnt == CNT_W'(BYTE_BITS - 1));
  assign w_byte     = {r_shift_in, w_mosi};
  assign w_cmd_addr = w_byte[ADDR_W-1:0];
  assign w_ptr_inc  = r_ptr + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: select changes dominate, command byte picks the data direction.
  always_comb begin
    w_state_nxt = r_state;
    if (w_ss_fall) begin
      w_state_nxt = ST_IDLE;
    end else if (w_ss_rise) begin
      w_state_nxt = ST_CMD;
    end else if (w_rise_ev && w_last_bit && r_state == ST_CMD) begin
      w_state_nxt = w_byte[CMD_W_BIT] ? ST_DATA_WR : ST_DATA_RD;
    end
  end

  // Bit counter, shift registers, pointer and pulse outputs.
  // Falls shift miso only mid-byte, so the MSB loaded on a byte's last rise
  // survives the fall that immediately follows it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt   <= '0;
      r_shift_in  <= '0;
      r_shift_out <= '0;
      r_ptr       <= '0;
      r_miso_oe   <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_ss_fall) begin
        r_miso_oe <= 1'b0;
        r_bit_cnt <= '0;
        if (r_state != ST_IDLE && r_bit_cnt != '0) r_frame_err <= 1'b1;
      end else if (w_ss_rise) begin
        r_miso_oe <= 1'b0;
        r_bit_cnt <= '0;
      end else if (w_rise_ev) begin
        r_shift_in <= w_byte[BYTE_BITS-2:0];
        r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
        if (w_last_bit) begin
          case (r_state)
            ST_CMD: begin
              r_ptr <= w_cmd_addr;
              if (!w_byte[CMD_W_BIT]) begin
                r_shift_out <= r_regs[w_cmd_addr];
                r_miso_oe   <= 1'b1;
              end
            end
            ST_DATA_WR: begin
              r_wr_strobe <= 1'b1;
              r_wr_addr   <= r_ptr;
              r_wr_data   <= w_byte;
              r_ptr       <= w_ptr_inc;
            end
            ST_DATA_RD: begin
              r_ptr       <= w_ptr_inc;
              r_shift_out <= r_regs[w_ptr_inc];
            end
            default: ;
          endcase
        end
      end else if (w_fall_ev && r_state == ST_DATA_RD && r_bit_cnt != '0) begin
        r_shift_out <= {r_shift_out[DATA_W-2:0], 1'b0};
      end
    end
  end

  // Register file commits during the strobe cycle, so local reads see the
  // old value alongside wr_strobe and the new value one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
    end else if (r_wr_strobe) begin
      r_regs[r_wr_addr] <= r_wr_data;
    end
  end

  assign miso      = r_miso_oe & r_shift_out[DATA_W-1];
  assign miso_oe   = r_miso_oe;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign rd_data   = r_regs[rd_addr];

endmodule
